unified_mem_arbiter: RTL and testbench

//  Shares one single-port, synchronous-read memory between the instruction-fetch

---
 rtl/unified_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter in front of one shared synchronous-read memory
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // Wait counter only needs to reach MEM_LAT-1 (at most 3).
  localparam int              CNT_W     = 2;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LAT - 1);
  localparam int              STRK_W    = $clog2(STARVE_MAX + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [STRK_W-1:0]   streak_q, streak_d;
  logic                gnt_data_q, gnt_data_d;   // 1 = current transaction belongs to the data side
  logic                gnt_we_q, gnt_we_d;       // 1 = current transaction is a store
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ack_q, if_ack_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                busy_q, busy_d;

  // Next-state and registered-output computation; every output is a flop.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    streak_d    = streak_q;
    gnt_data_d  = gnt_data_q;
    gnt_we_d    = gnt_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        // Data wins unless fetch has been passed over STARVE_MAX times in a row.
        if (d_req && (!if_req || (streak_q < STRK_MAX))) begin
          state_d     = S_ISSUE;
          gnt_data_d  = 1'b1;
          gnt_we_d    = d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STRK_MAX) begin
            streak_d = streak_q + STRK_W'(1);
          end
        end else if (if_req) begin
          state_d    = S_ISSUE;
          gnt_data_d = 1'b0;
          gnt_we_d   = 1'b0;
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          streak_d   = '0;
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        // Read data is valid in the last WAIT cycle; capture it and ack next cycle.
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
          if (gnt_data_q) begin
            d_ack_d = 1'b1;
            if (!gnt_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      streak_q    <= '0;
      gnt_data_q  <= 1'b0;
      gnt_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      streak_q    <= streak_d;
      gnt_data_q  <= gnt_data_d;
      gnt_we_q    <= gnt_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed bench for unified_mem_arbiter at MEM_LAT 1 and 3
module tb_unified_mem_arbiter;

  logic clk;
  logic rst;

  // Instance A: MEM_LAT=1
  logic        if_req1, if_ack1, d_req1, d_we1, d_ack1, mem_en1, mem_we1, busy1;
  logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  // Instance B: MEM_LAT=3
  logic        if_req3, if_ack3, d_req3, d_we3, d_ack3, mem_en3, mem_we3, busy3;
  logic [31:0] if_addr3, if_rdata3, d_addr3, d_wdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  int n_cmp;
  int n_bad;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ack(d_ack1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'h0050_0093;
      5:       return 32'h00A0_0113;
      6:       return 32'h0010_8093;
      9:       return 32'hCAFE_F00D;
      default: return (i >= 16 && i <= 21) ? 32'h1000_0000 + 32'(i) : 32'h0;
    endcase
  endfunction

  // Memory models: idle read bus shows a marker so a mistimed capture is visible.
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic        v1;
  logic [31:0] q1;
  logic        v3 [3];
  logic [31:0] q3 [3];

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem1[i] <= init_word(i);
    end else if (mem_en1 && mem_we1) begin
      mem1[mem_addr1[7:2]] <= mem_wdata1;
    end
    v1 <= mem_en1 && !mem_we1;
    q1 <= mem1[mem_addr1[7:2]];
  end
  assign mem_rdata1 = v1 ? q1 : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem3[i] <= init_word(i);
    end else if (mem_en3 && mem_we3) begin
      mem3[mem_addr3[7:2]] <= mem_wdata3;
    end
    v3[0] <= mem_en3 && !mem_we3;
    q3[0] <= mem3[mem_addr3[7:2]];
    v3[1] <= v3[0];
    q3[1] <= q3[0];
    v3[2] <= v3[1];
    q3[2] <= q3[1];
  end
  assign mem_rdata3 = v3[2] ? q3[2] : 32'hBAD0_BAD0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int acks;
  int nd;
  int order [6];
  int exp_order [6];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
    if_req3 = 0; if_addr3 = 0; d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;
    exp_order = '{1, 1, 1, 1, 2, 1};
    step();
    step();
    chk("rst_mem_en1", mem_en1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_if_ack1", if_ack1, 0);
    chk("rst_d_ack1", d_ack1, 0);
    chk("rst_mem_addr1", mem_addr1, 0);
    chk("rst_d_rdata1", d_rdata1, 0);
    chk("rst_busy3", busy3, 0);
    chk("rst_mem_we3", mem_we3, 0);
    rst = 1'b1;

    // Reset mid-WAIT at MEM_LAT=3
    step();
    d_req3 = 1; d_we3 = 0; d_addr3 = 32'h24;
    step();
    chk("t1_issue_en", mem_en3, 1);
    step();
    chk("t1_wait_busy", busy3, 1);
    rst = 1'b0;
    d_req3 = 0;
    #1;
    chk("t1_rst_busy", busy3, 0);
    chk("t1_rst_mem_addr", mem_addr3, 0);
    chk("t1_rst_mem_en", mem_en3, 0);
    chk("t1_rst_d_ack", d_ack3, 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t1_no_ack", d_ack3, 0);
      chk("t1_idle", busy3, 0);
    end
    chk("t1_rdata_kept", d_rdata3, 0);

    // Fetch only, MEM_LAT=1
    step();
    if_req1 = 1; if_addr1 = 32'h10;
    chk("t2_c0_en", mem_en1, 0);
    step();
    chk("t2_c1_en", mem_en1, 1);
    chk("t2_c1_we", mem_we1, 0);
    chk("t2_c1_addr", mem_addr1, 32'h10);
    step();
    chk("t2_c2_en", mem_en1, 0);
    chk("t2_c2_ack", if_ack1, 0);
    step();
    chk("t2_c3_ack", if_ack1, 1);
    chk("t2_c3_rdata", if_rdata1, 32'h0050_0093);
    chk("t2_c3_dack", d_ack1, 0);
    step();
    if_req1 = 0;
    chk("t2_c4_ack", if_ack1, 0);
    chk("t2_c4_busy", busy1, 0);

    // Store
    step();
    d_req1 = 1; d_we1 = 1; d_addr1 = 32'h20; d_wdata1 = 32'hDEAD_BEEF;
    step();
    chk("t3_c1_en", mem_en1, 1);
    chk("t3_c1_we", mem_we1, 1);
    chk("t3_c1_addr", mem_addr1, 32'h20);
    chk("t3_c1_wdata", mem_wdata1, 32'hDEAD_BEEF);
    step();
    chk("t3_c2_we", mem_we1, 0);
    step();
    chk("t3_c3_dack", d_ack1, 1);
    chk("t3_c3_rdata", d_rdata1, 0);
    chk("t3_c3_ifack", if_ack1, 0);
    step();
    d_req1 = 0; d_we1 = 0;
    chk("t3_c4_dack", d_ack1, 0);

    // Both request together: data first, then fetch
    step();
    if_req1 = 1; if_addr1 = 32'h14;
    d_req1 = 1; d_addr1 = 32'h20;
    step();
    chk("t4_c1_en", mem_en1, 1);
    chk("t4_c1_addr", mem_addr1, 32'h20);
    chk("t4_c1_we", mem_we1, 0);
    step();
    step();
    chk("t4_c3_dack", d_ack1, 1);
    chk("t4_c3_rdata", d_rdata1, 32'hDEAD_BEEF);
    chk("t4_c3_ifack", if_ack1, 0);
    step();
    d_req1 = 0;
    chk("t4_c4_en", mem_en1, 0);
    step();
    chk("t4_c5_en", mem_en1, 1);
    chk("t4_c5_addr", mem_addr1, 32'h14);
    step();
    step();
    chk("t4_c7_ifack", if_ack1, 1);
    chk("t4_c7_rdata", if_rdata1, 32'h00A0_0113);
    chk("t4_c7_dack", d_ack1, 0);
    step();
    if_req1 = 0;

    // Starvation limit
    step();
    if_req1 = 1; if_addr1 = 32'h18;
    d_req1 = 1; d_addr1 = 32'h40;
    acks = 0;
    nd = 0;
    for (int cyc = 0; cyc < 40 && acks < 6; cyc++) begin
      step();
      chk("t5_excl", {31'b0, d_ack1 & if_ack1}, 0);
      if (d_ack1) begin
        order[acks] = 1;
        chk("t5_drdata", d_rdata1, 32'h1000_0010 + 32'(nd));
        nd++;
        d_addr1 = 32'h40 + 32'(4 * nd);
        acks++;
      end else if (if_ack1) begin
        order[acks] = 2;
        chk("t5_ifrdata", if_rdata1, 32'h0010_8093);
        if_req1 = 0;
        acks++;
      end
      if (acks == 6) begin
        d_req1 = 0;
        if_req1 = 0;
      end
    end
    d_req1 = 0;
    if_req1 = 0;
    chk("t5_ack_count", acks, 6);
    for (int k = 0; k < 6; k++) begin
      chk("t5_order", order[k], exp_order[k]);
    end
    step();

    // Load at MEM_LAT=3
    step();
    d_req3 = 1; d_we3 = 0; d_addr3 = 32'h24;
    chk("t6_c0_busy", busy3, 0);
    step();
    chk("t6_c1_busy", busy3, 1);
    chk("t6_c1_en", mem_en3, 1);
    chk("t6_c1_addr", mem_addr3, 32'h24);
    step();
    chk("t6_c2_busy", busy3, 1);
    step();
    chk("t6_c3_busy", busy3, 1);
    step();
    chk("t6_c4_busy", busy3, 1);
    chk("t6_c4_dack", d_ack3, 0);
    step();
    chk("t6_c5_busy", busy3, 1);
    chk("t6_c5_dack", d_ack3, 1);
    chk("t6_c5_rdata", d_rdata3, 32'hCAFE_F00D);
    step();
    d_req3 = 0;
    chk("t6_c6_busy", busy3, 0);
    chk("t6_c6_dack", d_ack3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
